// File: rtl/ysyx_23060061_axil_pkg.sv
// Shared definitions for the AXI-Lite round-robin arbiter: response codes,
// channel FSM state encodings and the watchdog width.
package ysyx_23060061_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int WD_W = 16;

    typedef enum logic [2:0] {
        R_IDLE  = 3'd0,
        R_ADDR  = 3'd1,
        R_DATA  = 3'd2,
        R_ERR   = 3'd3,
        R_DRAIN = 3'd4
    } rd_state_e;

    typedef enum logic [2:0] {
        W_IDLE  = 3'd0,
        W_REQ   = 3'd1,
        W_RESP  = 3'd2,
        W_ERR   = 3'd3,
        W_DRAIN = 3'd4
    } wr_state_e;

    // Saturating watchdog increment.
    function automatic logic [WD_W-1:0] wd_step(input logic [WD_W-1:0] v);
        return (v == {WD_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ysyx_23060061_rr_picker.sv
// Combinational round-robin picker: selects the first requester at or after
// the pointer, wrapping, and reports it as one-hot and as an index.
module ysyx_23060061_rr_picker #(
    parameter int NUM_M = 2
) (
    input  logic [NUM_M-1:0]         req_i,
    input  logic [$clog2(NUM_M)-1:0] ptr_i,
    output logic [NUM_M-1:0]         gnt_o,
    output logic [$clog2(NUM_M)-1:0] idx_o
);
    localparam int IW = $clog2(NUM_M);

    int   cand;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_M; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NUM_M) begin
                cand = cand - NUM_M;
            end
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/ysyx_23060061_axil_rr_arbiter.sv
// N-master to 1-slave AXI-Lite arbiter with independent round-robin read and
// write scheduling and a response watchdog that converts a hung slave into SLVERR.
module ysyx_23060061_axil_rr_arbiter
    import ysyx_23060061_axil_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [NUM_M*32-1:0]  m_araddr,
    input  logic [NUM_M-1:0]     m_arvalid,
    output logic [NUM_M-1:0]     m_arready,
    output logic [31:0]          m_rdata,
    output logic [1:0]           m_rresp,
    output logic [NUM_M-1:0]     m_rvalid,
    input  logic [NUM_M-1:0]     m_rready,

    input  logic [NUM_M*32-1:0]  m_awaddr,
    input  logic [NUM_M-1:0]     m_awvalid,
    output logic [NUM_M-1:0]     m_awready,
    input  logic [NUM_M*32-1:0]  m_wdata,
    input  logic [NUM_M*4-1:0]   m_wstrb,
    input  logic [NUM_M-1:0]     m_wvalid,
    output logic [NUM_M-1:0]     m_wready,
    output logic [1:0]           m_bresp,
    output logic [NUM_M-1:0]     m_bvalid,
    input  logic [NUM_M-1:0]     m_bready,

    output logic [31:0]          s_araddr,
    output logic                 s_arvalid,
    input  logic                 s_arready,
    input  logic [31:0]          s_rdata,
    input  logic [1:0]           s_rresp,
    input  logic                 s_rvalid,
    output logic                 s_rready,

    output logic [31:0]          s_awaddr,
    output logic                 s_awvalid,
    input  logic                 s_awready,
    output logic [31:0]          s_wdata,
    output logic [3:0]           s_wstrb,
    output logic                 s_wvalid,
    input  logic                 s_wready,
    input  logic [1:0]           s_bresp,
    input  logic                 s_bvalid,
    output logic                 s_bready,

    output logic                 rd_busy,
    output logic                 wr_busy
);
    localparam int             IW       = $clog2(NUM_M);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_M - 1);
    localparam bit             WD_EN    = (TIMEOUT != 0);
    // The watchdog holds completed wait cycles, so it fires on its TIMEOUT-th cycle.
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] g);
        return (g == LAST_IDX) ? '0 : g + 1'b1;
    endfunction

    rd_state_e       rd_state_q, rd_state_d;
    logic [IW-1:0]   rd_grant_q, rd_grant_d;
    logic [IW-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [WD_W-1:0] rd_wd_q,    rd_wd_d;

    wr_state_e       wr_state_q, wr_state_d;
    logic [IW-1:0]   wr_grant_q, wr_grant_d;
    logic [IW-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [WD_W-1:0] wr_wd_q,    wr_wd_d;
    logic            aw_done_q,  aw_done_d;
    logic            w_done_q,   w_done_d;

    logic [NUM_M-1:0] rd_pick_gnt, wr_pick_gnt;
    logic [IW-1:0]    rd_pick_idx, wr_pick_idx;

    ysyx_23060061_rr_picker #(.NUM_M(NUM_M)) u_rd_picker (
        .req_i (m_arvalid),
        .ptr_i (rd_ptr_q),
        .gnt_o (rd_pick_gnt),
        .idx_o (rd_pick_idx)
    );

    // Only AW requests write arbitration; a lone W beat waits for its address.
    ysyx_23060061_rr_picker #(.NUM_M(NUM_M)) u_wr_picker (
        .req_i (m_awvalid),
        .ptr_i (wr_ptr_q),
        .gnt_o (wr_pick_gnt),
        .idx_o (wr_pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state_q <= R_IDLE;
            rd_grant_q <= '0;
            rd_ptr_q   <= '0;
            rd_wd_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_grant_q <= rd_grant_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_wd_q    <= rd_wd_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_grant_d = rd_grant_q;
        rd_ptr_d   = rd_ptr_q;
        rd_wd_d    = rd_wd_q;
        m_arready  = '0;
        m_rvalid   = '0;
        m_rdata    = '0;
        m_rresp    = RESP_OKAY;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_araddr   = m_araddr[32*int'(rd_grant_q) +: 32];

        case (rd_state_q)
            R_IDLE: begin
                if (|rd_pick_gnt) begin
                    rd_grant_d = rd_pick_idx;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                s_arvalid             = m_arvalid[rd_grant_q];
                m_arready[rd_grant_q] = s_arready;
                if (m_arvalid[rd_grant_q] && s_arready) begin
                    rd_state_d = R_DATA;
                    rd_wd_d    = '0;
                end
            end
            R_DATA: begin
                m_rvalid[rd_grant_q] = s_rvalid;
                s_rready             = m_rready[rd_grant_q];
                m_rdata              = s_rdata;
                m_rresp              = s_rresp;
                // A beat arriving on the expiry cycle still counts as the real response.
                if (s_rvalid && m_rready[rd_grant_q]) begin
                    rd_ptr_d   = ptr_after(rd_grant_q);
                    rd_state_d = R_IDLE;
                end else if (!s_rvalid && WD_EN && (rd_wd_q == WD_LAST)) begin
                    rd_state_d = R_ERR;
                end else begin
                    rd_wd_d = wd_step(rd_wd_q);
                end
            end
            R_ERR: begin
                m_rvalid[rd_grant_q] = 1'b1;
                m_rresp              = RESP_SLVERR;
                if (m_rready[rd_grant_q]) begin
                    rd_state_d = R_DRAIN;
                end
            end
            R_DRAIN: begin
                s_rready = 1'b1;
                if (s_rvalid) begin
                    rd_ptr_d   = ptr_after(rd_grant_q);
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_state_q <= W_IDLE;
            wr_grant_q <= '0;
            wr_ptr_q   <= '0;
            wr_wd_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_grant_q <= wr_grant_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_wd_q    <= wr_wd_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_grant_d = wr_grant_q;
        wr_ptr_d   = wr_ptr_q;
        wr_wd_d    = wr_wd_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        m_awready  = '0;
        m_wready   = '0;
        m_bvalid   = '0;
        m_bresp    = RESP_OKAY;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        s_awaddr   = m_awaddr[32*int'(wr_grant_q) +: 32];
        s_wdata    = m_wdata[32*int'(wr_grant_q) +: 32];
        s_wstrb    = m_wstrb[4*int'(wr_grant_q) +: 4];

        case (wr_state_q)
            W_IDLE: begin
                if (|wr_pick_gnt) begin
                    wr_grant_d = wr_pick_idx;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    wr_state_d = W_REQ;
                end
            end
            W_REQ: begin
                // AW and W complete in either order; a finished channel is masked off.
                s_awvalid             = m_awvalid[wr_grant_q] & ~aw_done_q;
                m_awready[wr_grant_q] = s_awready & ~aw_done_q;
                s_wvalid              = m_wvalid[wr_grant_q] & ~w_done_q;
                m_wready[wr_grant_q]  = s_wready & ~w_done_q;
                aw_done_d             = aw_done_q | (s_awvalid & s_awready);
                w_done_d              = w_done_q | (s_wvalid & s_wready);
                if (aw_done_d && w_done_d) begin
                    wr_state_d = W_RESP;
                    wr_wd_d    = '0;
                end
            end
            W_RESP: begin
                m_bvalid[wr_grant_q] = s_bvalid;
                s_bready             = m_bready[wr_grant_q];
                m_bresp              = s_bresp;
                if (s_bvalid && m_bready[wr_grant_q]) begin
                    wr_ptr_d   = ptr_after(wr_grant_q);
                    wr_state_d = W_IDLE;
                end else if (!s_bvalid && WD_EN && (wr_wd_q == WD_LAST)) begin
                    wr_state_d = W_ERR;
                end else begin
                    wr_wd_d = wd_step(wr_wd_q);
                end
            end
            W_ERR: begin
                m_bvalid[wr_grant_q] = 1'b1;
                m_bresp              = RESP_SLVERR;
                if (m_bready[wr_grant_q]) begin
                    wr_state_d = W_DRAIN;
                end
            end
            W_DRAIN: begin
                s_bready = 1'b1;
                if (s_bvalid) begin
                    wr_ptr_d   = ptr_after(wr_grant_q);
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign rd_busy = (rd_state_q != R_IDLE);
    assign wr_busy = (wr_state_q != W_IDLE);

endmodule

// File: tb/tb_ysyx_23060061_axil_rr_arbiter.sv
// Directed bench for the AXI-Lite round-robin arbiter: a read-vector table
// plus hand-written concurrent, timeout and reset sequences.
module tb_ysyx_23060061_axil_rr_arbiter;
    localparam int NUM_M   = 2;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] m_araddr;
    logic [1:0]  m_arvalid, m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [1:0]  m_rvalid, m_rready;
    logic [63:0] m_awaddr;
    logic [1:0]  m_awvalid, m_awready;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic [1:0]  m_bvalid, m_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid, s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid, s_rready;
    logic [31:0] s_awaddr;
    logic        s_awvalid, s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid, s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid, s_bready;
    logic        rd_busy, wr_busy;

    always #5 clk = ~clk;

    ysyx_23060061_axil_rr_arbiter #(.NUM_M(NUM_M), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .rd_busy(rd_busy), .wr_busy(wr_busy)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_addr_of[2];

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  exp_gnt;
        logic [31:0] data;
        int          lat;
    } rd_vec_t;
    rd_vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m_arvalid = '0; m_rready = '0; m_awvalid = '0; m_wvalid = '0; m_bready = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
    endtask

    // Leaves the bench at posedge+1 of the first cycle out of reset.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // One complete read with an immediate-AR slave; entered and left at posedge+1 in R_IDLE.
    task automatic do_read(input logic [1:0] req, input logic [1:0] exp_gnt,
                           input logic [31:0] data, input int lat, input string tag);
        int g;
        int wait_cyc;
        logic [31:0] exp_d;
        g = exp_gnt[1] ? 1 : 0;
        exp_q.push_back(data);
        m_arvalid = req;
        @(negedge clk);
        chk({tag, "_idle_arvalid"}, 64'(s_arvalid), 64'(0));
        wait_cyc = 0;
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (!s_arvalid && wait_cyc < 8);
        chk({tag, "_arb_latency"}, 64'(wait_cyc), 64'(1));
        chk({tag, "_araddr"}, 64'(s_araddr), 64'(rd_addr_of[g]));
        chk({tag, "_arready_low"}, 64'(m_arready), 64'(0));
        s_arready = 1'b1;
        #1;
        chk({tag, "_arready"}, 64'(m_arready), 64'(exp_gnt));
        @(posedge clk); #1;
        s_arready = 1'b0;
        m_arvalid = '0;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk({tag, "_rvalid_wait"}, 64'(m_rvalid), 64'(0));
            @(posedge clk); #1;
        end
        s_rvalid = 1'b1; s_rdata = data; s_rresp = 2'b00; m_rready = 2'b11;
        @(negedge clk);
        exp_d = exp_q.pop_front();
        chk({tag, "_rvalid"}, 64'(m_rvalid), 64'(exp_gnt));
        chk({tag, "_rdata"}, 64'(m_rdata), 64'(exp_d));
        chk({tag, "_rresp"}, 64'(m_rresp), 64'(0));
        @(posedge clk); #1;
        s_rvalid = 1'b0; s_rdata = '0; m_rready = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        rd_addr_of[0] = 32'h8000_0000;
        rd_addr_of[1] = 32'h9000_0010;
        m_araddr = {rd_addr_of[1], rd_addr_of[0]};
        m_awaddr = {32'hA000_0040, 32'h8000_0100};
        m_wdata  = {32'h0BAD_F00D, 32'h1234_5678};
        m_wstrb  = {4'h3, 4'hF};
        // Pointer is 1 after the single read from m0; grants below follow from that.
        vecs[0] = '{req: 2'b11, exp_gnt: 2'b10, data: 32'h1111_0001, lat: 0};
        vecs[1] = '{req: 2'b01, exp_gnt: 2'b01, data: 32'h2222_0002, lat: 1};
        vecs[2] = '{req: 2'b01, exp_gnt: 2'b01, data: 32'h3333_0003, lat: 0};
        vecs[3] = '{req: 2'b10, exp_gnt: 2'b10, data: 32'h4444_0004, lat: 3};
        vecs[4] = '{req: 2'b11, exp_gnt: 2'b01, data: 32'h5555_0005, lat: 0};
        vecs[5] = '{req: 2'b11, exp_gnt: 2'b10, data: 32'h6666_0006, lat: 1};
        vecs[6] = '{req: 2'b10, exp_gnt: 2'b10, data: 32'h7777_0007, lat: 0};

        // Reset state, with requests pending that must be ignored.
        idle_inputs();
        m_arvalid = 2'b11; m_awvalid = 2'b11; m_wvalid = 2'b11;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valids", 64'({m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid}), 64'(0));
        chk("rst_readys", 64'({m_arready, m_awready, m_wready, s_rready, s_bready}), 64'(0));
        chk("rst_busy", 64'({rd_busy, wr_busy}), 64'(0));
        chk("rst_payload", 64'({m_rdata, m_rresp, m_bresp}), 64'(0));
        do_reset();

        // Single read from m0, slave latency 2.
        do_read(2'b01, 2'b01, 32'hDEAD_BEEF, 2, "single");
        for (int i = 0; i < 7; i++) begin
            do_read(vecs[i].req, vecs[i].exp_gnt, vecs[i].data, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Contention from a fresh pointer.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_read(2'b11, (i % 2 == 0) ? 2'b01 : 2'b10, 32'hC0DE_0000 + 32'(i), 0,
                    $sformatf("cont%0d", i));
        end

        // Concurrent: m0 writes (W three cycles before AW) while m1 reads.
        do_reset();
        m_wvalid = 2'b01; m_arvalid = 2'b10;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("cc_w_alone_busy", 64'(wr_busy), 64'(0));
            chk("cc_w_alone_wvalid", 64'({s_wvalid, m_wready}), 64'(0));
            if (k == 1) begin
                chk("cc_ar", 64'({s_arvalid, m_arready}), 64'({1'b1, 2'b10}));
                chk("cc_araddr", 64'(s_araddr), 64'(rd_addr_of[1]));
            end
            @(posedge clk); #1;
            if (k == 1) begin
                m_arvalid = '0;
                s_arready = 1'b0;
            end
        end
        m_awvalid = 2'b01;
        @(posedge clk); #1;
        s_awready = 1'b0;
        @(negedge clk);
        chk("cc_req_valids", 64'({s_awvalid, s_wvalid}), 64'(2'b11));
        chk("cc_wpayload", 64'({s_wdata, s_wstrb}), 64'({32'h1234_5678, 4'hF}));
        chk("cc_awaddr", 64'(s_awaddr), 64'(32'h8000_0100));
        chk("cc_readys", 64'({m_awready, m_wready}), 64'({2'b00, 2'b01}));
        @(posedge clk); #1;
        @(negedge clk);
        chk("cc_w_sticky", 64'({s_wvalid, m_wready, s_awvalid}), 64'({1'b0, 2'b00, 1'b1}));
        s_awready = 1'b1;
        #1;
        chk("cc_awready", 64'(m_awready), 64'(2'b01));
        @(posedge clk); #1;
        m_awvalid = '0; m_wvalid = '0; s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 2'b01;
        @(negedge clk);
        chk("cc_bvalid", 64'({m_bvalid, m_bresp, s_bready}), 64'({2'b01, 2'b00, 1'b1}));
        chk("cc_overlap", 64'({rd_busy, wr_busy}), 64'(2'b11));
        @(posedge clk); #1;
        s_bvalid = 1'b0; m_bready = '0;
        @(negedge clk);
        chk("cc_w_done", 64'({wr_busy, m_bvalid}), 64'(0));
        s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001; m_rready = 2'b10;
        #1;
        chk("cc_rvalid", 64'({m_rvalid, m_rdata}), 64'({2'b10, 32'hCAFE_0001}));
        @(posedge clk); #1;
        s_rvalid = 1'b0; m_rready = '0;
        @(negedge clk);
        chk("cc_r_done", 64'(rd_busy), 64'(0));

        // Watchdog: slave never answers; SLVERR exactly TIMEOUT edges after the AR handshake.
        do_reset();
        m_arvalid = 2'b01; s_arready = 1'b1; s_rdata = 32'hBADB_AD00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_arvalid = '0; s_arready = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), 64'(m_rvalid), 64'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_err", 64'({m_rvalid, m_rresp, m_rdata, s_rready}), 64'({2'b01, 2'b10, 32'h0, 1'b0}));
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_err_hold", 64'(m_rvalid), 64'(2'b01));
        m_rready = 2'b01;
        @(posedge clk); #1;
        m_rready = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_drain", 64'({m_rvalid, s_rready, rd_busy}), 64'({2'b00, 1'b1, 1'b1}));
            @(posedge clk); #1;
        end
        s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA; m_rready = 2'b11;
        @(negedge clk);
        chk("to_late_beat", 64'(m_rvalid), 64'(0));
        @(posedge clk); #1;
        s_rvalid = 1'b0; m_rready = '0;
        @(negedge clk);
        chk("to_idle", 64'(rd_busy), 64'(0));
        m_arvalid = 2'b11;
        @(negedge clk);
        chk("to_ptr_adv", 64'({s_arvalid, s_araddr}), 64'({1'b1, rd_addr_of[1]}));

        // Reset during W_RESP, then m1 write is granted first.
        do_reset();
        m_awvalid = 2'b01; m_wvalid = 2'b01; s_awready = 1'b1; s_wready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_awvalid = '0; m_wvalid = '0;
        s_bvalid = 1'b1; s_bresp = 2'b01; m_bready = 2'b01;
        @(negedge clk);
        chk("rw_resp", 64'({m_bvalid, s_bready, m_bresp, wr_busy}), 64'({2'b01, 1'b1, 2'b01, 1'b1}));
        #2;
        rst = 1'b0;
        #1;
        chk("rw_async", 64'({m_bvalid, s_bready, m_bresp, wr_busy}), 64'(0));
        s_bvalid = 1'b0; m_bready = '0;
        @(negedge clk);
        rst = 1'b1;
        m_awvalid = 2'b10; m_wvalid = 2'b10;
        @(negedge clk);
        chk("rw_m1_grant", 64'({m_awready, m_wready}), 64'({2'b10, 2'b10}));
        chk("rw_m1_payload", 64'({s_awaddr, s_wdata}), 64'({32'hA000_0040, 32'h0BAD_F00D}));
        @(posedge clk); #1;
        m_awvalid = '0; m_wvalid = '0;
        s_bvalid = 1'b1; s_bresp = 2'b00; m_bready = 2'b10;
        @(negedge clk);
        chk("rw_m1_b", 64'({m_bvalid, m_bresp}), 64'({2'b10, 2'b00}));
        @(posedge clk); #1;
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
